// File: rtl/nmc_pkg.sv
// Shared types for the near-memory-compute array and its host-side initiator.
package nmc_pkg;

  localparam int NMC_ADDR_W   = 4;
  localparam int NMC_ENTRY_W  = 8;
  localparam int NMC_FEAT_W   = 8;
  localparam int NMC_RESULT_W = 8;
  localparam int NMC_ID_W     = 4;

  typedef struct packed {
    logic [NMC_ADDR_W-1:0]  addr;
    logic [NMC_ENTRY_W-1:0] entry;
  } nmc_wr_req_t;

  typedef struct packed {
    logic [NMC_ID_W-1:0]   id;
    logic                  id_vld;
    logic [NMC_ADDR_W-1:0] addr;
    logic [NMC_FEAT_W-1:0] feature;
  } nmc_qr_req_t;

  typedef struct packed {
    logic                    valid;
    logic                    found;
    logic [NMC_RESULT_W-1:0] result;
  } nmc_qr_resp_t;

  typedef enum logic {
    NMC_OP_WR = 1'b0,
    NMC_OP_QR = 1'b1
  } nmc_op_e;

  typedef struct packed {
    nmc_op_e                op;
    logic [NMC_ADDR_W-1:0]  addr;
    logic [NMC_ENTRY_W-1:0] entry;
    logic [NMC_FEAT_W-1:0]  feature;
  } nmc_host_cmd_t;

  typedef struct packed {
    logic [NMC_ID_W-1:0]     id;
    logic                    found;
    logic [NMC_RESULT_W-1:0] result;
  } nmc_host_resp_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } nmc_host_state_e;

endpackage

// File: rtl/nmc_sync_fifo.sv
// Synchronous FIFO with registered storage and count-based full/empty flags.
// No fall-through: data pushed in cycle N is visible at dout from cycle N+1.
module nmc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == DEPTH_C);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A pop frees a slot in the same cycle, so push is legal even when full.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/nmc_host_if.sv
// Host-side initiator: splits host commands into nmc write/query pushes, tags
// queries, and returns nmc responses to the host in order with tags attached.
module nmc_host_if
  import nmc_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int ID_W            = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  nmc_host_cmd_t                      cmd,
  output nmc_wr_req_t                        nmc_wr_req,
  output logic                               nwr_push,
  input  logic                               nwr_full,
  output nmc_qr_req_t                        nmc_qr_req,
  output logic                               nqr_push,
  input  logic                               nqr_full,
  input  nmc_qr_resp_t                       nmc_qr_resp,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output nmc_host_resp_t                     resp,
  input  logic                               drain_req,
  output logic                               drain_done,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_orphan
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int RW = $bits(nmc_host_resp_t);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  // Handshakes: a transfer happens in any cycle where valid and ready are both
  // high; ready never looks at valid, and valid never waits for ready.

  nmc_host_state_e state_q, state_d;
  logic [ID_W-1:0] tag_ctr_q, tag_ctr_d;
  logic [CW-1:0]   out_q, out_d;
  logic            orphan_q, orphan_d;

  logic            tag_full, tag_empty, tag_pop;
  logic [ID_W-1:0] tag_head;
  logic            rsp_full, rsp_empty, rsp_push, resp_hs;
  logic [RW-1:0]   rsp_dout;
  nmc_host_resp_t  rsp_in;
  logic            q_credit_ok;

  // Credits alone keep both FIFOs from overflowing; the full flags are a backstop.
  assign q_credit_ok = (out_q < MAX_CNT) && !tag_full && !rsp_full;

  always_comb begin
    cmd_ready = 1'b0;
    if (!rst && state_q == S_RUN) begin
      if (cmd.op == NMC_OP_WR) cmd_ready = !nwr_full;
      else                     cmd_ready = !nqr_full && q_credit_ok;
    end
  end

  assign nwr_push = cmd_valid && cmd_ready && (cmd.op == NMC_OP_WR);
  assign nqr_push = cmd_valid && cmd_ready && (cmd.op == NMC_OP_QR);

  always_comb begin
    nmc_wr_req = '0;
    nmc_qr_req = '0;
    if (nwr_push) begin
      nmc_wr_req.addr  = cmd.addr;
      nmc_wr_req.entry = cmd.entry;
    end
    if (nqr_push) begin
      nmc_qr_req.id      = NMC_ID_W'(tag_ctr_q);
      nmc_qr_req.id_vld  = 1'b1;
      nmc_qr_req.addr    = cmd.addr;
      nmc_qr_req.feature = cmd.feature;
    end
  end

  assign tag_pop  = nmc_qr_resp.valid && !tag_empty;
  assign rsp_push = tag_pop;

  always_comb begin
    rsp_in        = '0;
    rsp_in.id     = NMC_ID_W'(tag_head);
    rsp_in.found  = nmc_qr_resp.found;
    rsp_in.result = nmc_qr_resp.result;
  end

  nmc_sync_fifo #(.WIDTH(ID_W), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (nqr_push),
    .din   (tag_ctr_q),
    .pop   (tag_pop),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  nmc_sync_fifo #(.WIDTH(RW), .DEPTH(MAX_OUTSTANDING)) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .din   (rsp_in),
    .pop   (resp_hs),
    .dout  (rsp_dout),
    .full  (rsp_full),
    .empty (rsp_empty)
  );

  assign resp_valid  = !rsp_empty;
  assign resp_hs     = resp_valid && resp_ready;
  assign resp        = resp_valid ? nmc_host_resp_t'(rsp_dout) : '0;
  assign outstanding = out_q;
  assign err_orphan  = orphan_q;
  assign drain_done  = (state_q == S_DONE);

  always_comb begin
    tag_ctr_d = nqr_push ? tag_ctr_q + ID_W'(1) : tag_ctr_q;
    orphan_d  = orphan_q || (nmc_qr_resp.valid && tag_empty);
    out_d     = out_q;
    case ({nqr_push, resp_hs})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
  end

  // Looking at next-cycle credits lets drain_done land the cycle after the last pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (drain_req) state_d = S_DRAIN;
      S_DRAIN: if (out_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RUN;
      tag_ctr_q <= '0;
      out_q     <= '0;
      orphan_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tag_ctr_q <= tag_ctr_d;
      out_q     <= out_d;
      orphan_q  <= orphan_d;
    end
  end

endmodule

// File: tb/tb_nmc_host_if.sv
// Self-checking bench for nmc_host_if: directed scenarios plus randomized
// traffic compared every cycle against a queue-based model of the block.
module tb_nmc_host_if;
  import nmc_pkg::*;

  localparam int MAXO = 8;
  localparam int RW   = $bits(nmc_host_resp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           cmd_valid, cmd_ready;
  nmc_host_cmd_t  cmd;
  nmc_wr_req_t    nmc_wr_req;
  logic           nwr_push, nwr_full;
  nmc_qr_req_t    nmc_qr_req;
  logic           nqr_push, nqr_full;
  nmc_qr_resp_t   nmc_qr_resp;
  logic           resp_valid, resp_ready;
  nmc_host_resp_t resp;
  logic           drain_req, drain_done;
  logic [3:0]     outstanding;
  logic           err_orphan;

  nmc_host_if #(.MAX_OUTSTANDING(MAXO), .ID_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd         (cmd),
    .nmc_wr_req  (nmc_wr_req),
    .nwr_push    (nwr_push),
    .nwr_full    (nwr_full),
    .nmc_qr_req  (nmc_qr_req),
    .nqr_push    (nqr_push),
    .nqr_full    (nqr_full),
    .nmc_qr_resp (nmc_qr_resp),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp        (resp),
    .drain_req   (drain_req),
    .drain_done  (drain_done),
    .outstanding (outstanding),
    .err_orphan  (err_orphan)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int               m_out     = 0;
  logic [3:0]       m_tag_ctr = '0;
  logic [3:0]       m_tags[$];
  logic [RW-1:0]    exp_q[$];
  logic             m_orphan  = 1'b0;
  int               m_mode    = 0;   // 0 running, 1 draining, 2 done pulse

  function automatic logic pred_ready();
    if (rst || m_mode != 0) return 1'b0;
    if (cmd.op == NMC_OP_QR) return !nqr_full && (m_out < MAXO);
    return !nwr_full;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic          acc, hs, have;
    logic [RW-1:0] nr;
    logic [3:0]    t;
    if (rst) begin
      m_out = 0; m_tag_ctr = '0; m_tags.delete(); exp_q.delete();
      m_orphan = 1'b0; m_mode = 0;
    end else begin
      acc  = cmd_valid && pred_ready();
      hs   = (exp_q.size() > 0) && resp_ready;
      have = 1'b0;
      nr   = '0;
      if (nmc_qr_resp.valid) begin
        if (m_tags.size() > 0) begin
          t    = m_tags.pop_front();
          nr   = {t, nmc_qr_resp.found, nmc_qr_resp.result};
          have = 1'b1;
        end else m_orphan = 1'b1;
      end
      if (hs) begin
        void'(exp_q.pop_front());
        m_out--;
      end
      if (have) exp_q.push_back(nr);
      if (acc && cmd.op == NMC_OP_QR) begin
        m_tags.push_back(m_tag_ctr);
        m_tag_ctr = m_tag_ctr + 4'd1;
        m_out++;
      end
      case (m_mode)
        0: if (drain_req) m_mode = 1;
        1: if (m_out == 0) m_mode = 2;
        default: m_mode = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    logic er, wp, qp;
    er = pred_ready();
    wp = cmd_valid && er && (cmd.op == NMC_OP_WR);
    qp = cmd_valid && er && (cmd.op == NMC_OP_QR);
    check("cmd_ready", 32'(cmd_ready), 32'(er));
    check("nwr_push", 32'(nwr_push), 32'(wp));
    check("nqr_push", 32'(nqr_push), 32'(qp));
    check("nmc_wr_req", 32'(nmc_wr_req), wp ? 32'({cmd.addr, cmd.entry}) : 32'd0);
    check("nmc_qr_req", 32'(nmc_qr_req),
          qp ? 32'({m_tag_ctr, 1'b1, cmd.addr, cmd.feature}) : 32'd0);
    check("resp_valid", 32'(resp_valid), 32'(exp_q.size() > 0));
    check("resp", 32'(resp), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
    check("outstanding", 32'(outstanding), 32'(m_out));
    check("drain_done", 32'(drain_done), 32'(m_mode == 2));
    check("err_orphan", 32'(err_orphan), 32'(m_orphan));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; nmc_qr_resp = '0; resp_ready = 1'b0; drain_req = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send_cmd(input nmc_op_e op, input logic [3:0] addr, input logic [7:0] entry,
                          input logic [7:0] feat, output logic [3:0] id_seen);
    logic ok;
    ok = 1'b0;
    id_seen = '0;
    cmd_valid = 1'b1;
    cmd.op = op; cmd.addr = addr; cmd.entry = entry; cmd.feature = feat;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        id_seen = nmc_qr_req.id;
      end
      step();
      if (ok) break;
    end
    cmd_valid = 1'b0;
    check("send_cmd_accept", 32'(ok), 32'd1);
  endtask

  task automatic nmc_respond(input logic found, input logic [7:0] result);
    nmc_qr_resp.valid = 1'b1;
    nmc_qr_resp.found = found;
    nmc_qr_resp.result = result;
    step();
    nmc_qr_resp = '0;
  endtask

  task automatic host_pop(output nmc_host_resp_t r);
    logic ok;
    ok = 1'b0;
    r = '0;
    resp_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        ok = 1'b1;
        r = resp;
      end
      step();
      if (ok) break;
    end
    resp_ready = 1'b0;
    check("host_pop_valid", 32'(ok), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [3:0]     id;
    nmc_host_resp_t r;
    logic [7:0]     res [3];
    int             dd_cnt, dd_c, last_pop, pend;
    logic           ready_after, pushed;

    rst = 1'b1; cmd_valid = 1'b0; cmd = '0; nwr_full = 1'b0; nqr_full = 1'b0;
    nmc_qr_resp = '0; resp_ready = 1'b0; drain_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outstanding", 32'(outstanding), 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_err_orphan", 32'(err_orphan), 32'd0);
    check("reset_nqr_push", 32'(nqr_push), 32'd0);
    step();
    rst = 1'b0;

    // Write pass-through and write back-pressure
    cmd_valid = 1'b1;
    cmd.op = NMC_OP_WR; cmd.addr = 4'h3; cmd.entry = 8'h5A; cmd.feature = 8'h00;
    @(negedge clk);
    check("wr_push", 32'(nwr_push), 32'd1);
    check("wr_req", 32'(nmc_wr_req), 32'h35A);
    step();
    nwr_full = 1'b1;
    @(negedge clk);
    check("wr_full_ready", 32'(cmd_ready), 32'd0);
    check("wr_full_push", 32'(nwr_push), 32'd0);
    step();
    cmd_valid = 1'b0; nwr_full = 1'b0;

    // Query round trip
    res[0] = 8'h11; res[1] = 8'h22; res[2] = 8'h33;
    for (int i = 0; i < 3; i++) send_cmd(NMC_OP_QR, 4'(i), 8'h00, 8'(8'h10 + i), id);
    for (int i = 0; i < 3; i++) begin
      nmc_respond(1'b1, res[i]);
      @(negedge clk);
      check("rt_resp_valid", 32'(resp_valid), 32'd1);
      check("rt_front_id", 32'(resp.id), 32'd0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      host_pop(r);
      check("rt_id", 32'(r.id), 32'(i));
      check("rt_result", 32'(r.result), 32'(res[i]));
      check("rt_found", 32'(r.found), 32'd1);
    end

    // Credit limit
    do_reset();
    for (int i = 0; i < 8; i++) send_cmd(NMC_OP_QR, 4'(i), 8'h00, 8'(i), id);
    cmd_valid = 1'b1; cmd.op = NMC_OP_QR; cmd.addr = 4'h9; cmd.feature = 8'h99;
    @(negedge clk);
    check("credit_ready", 32'(cmd_ready), 32'd0);
    check("credit_outstanding", 32'(outstanding), 32'd8);
    step();
    nmc_respond(1'b1, 8'h77);
    resp_ready = 1'b1;
    @(negedge clk);
    check("credit_pop_valid", 32'(resp_valid), 32'd1);
    step();
    resp_ready = 1'b0;
    @(negedge clk);
    check("credit_ninth_push", 32'(nqr_push), 32'd1);
    check("credit_ninth_id", 32'(nmc_qr_req.id), 32'd8);
    step();
    cmd_valid = 1'b0;

    // Tag wrap
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send_cmd(NMC_OP_QR, 4'(i), 8'h00, 8'(i), id);
      check("wrap_issue_id", 32'(id), 32'(i % 16));
      nmc_respond(1'(i), 8'(i * 7));
      host_pop(r);
      check("wrap_resp_id", 32'(r.id), 32'(i % 16));
      check("wrap_result", 32'(r.result), 32'((i * 7) % 256));
    end

    // Drain
    do_reset();
    for (int i = 0; i < 4; i++) send_cmd(NMC_OP_QR, 4'(i), 8'h00, 8'(i), id);
    for (int i = 0; i < 4; i++) nmc_respond(1'b1, 8'(8'h40 + i));
    drain_req = 1'b1;
    step();
    drain_req = 1'b0;
    cmd_valid = 1'b1; cmd.op = NMC_OP_WR; cmd.addr = 4'h1; cmd.entry = 8'h01;
    @(negedge clk);
    check("drain_stall", 32'(cmd_ready), 32'd0);
    step();
    dd_cnt = 0; dd_c = -10; last_pop = -1; ready_after = 1'b0;
    resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) last_pop = c;
      if (drain_done) begin dd_cnt++; dd_c = c; end
      if (c == dd_c + 1) ready_after = cmd_ready;
      step();
      if (c == 3) resp_ready = 1'b0;
    end
    cmd_valid = 1'b0;
    check("drain_done_count", 32'(dd_cnt), 32'd1);
    check("drain_done_cycle", 32'(dd_c), 32'd4);
    check("drain_done_after_pop", 32'(dd_c), 32'(last_pop + 1));
    check("drain_resume_ready", 32'(ready_after), 32'd1);

    // Reset with queries in flight, then a late nmc response
    do_reset();
    for (int i = 0; i < 2; i++) send_cmd(NMC_OP_QR, 4'(i), 8'h00, 8'(i), id);
    rst = 1'b1;
    step();
    rst = 1'b0;
    nmc_respond(1'b1, 8'h44);
    @(negedge clk);
    check("orphan_outstanding", 32'(outstanding), 32'd0);
    check("orphan_resp_valid", 32'(resp_valid), 32'd0);
    check("orphan_flag", 32'(err_orphan), 32'd1);
    step();

    // Randomized traffic with an in-order nmc responder
    do_reset();
    pend = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      cmd_valid   = ($urandom_range(0, 3) != 0);
      cmd.op      = nmc_op_e'($urandom_range(0, 1));
      cmd.addr    = 4'($urandom_range(0, 15));
      cmd.entry   = 8'($urandom_range(0, 255));
      cmd.feature = 8'($urandom_range(0, 255));
      nwr_full    = ($urandom_range(0, 4) == 0);
      nqr_full    = ($urandom_range(0, 4) == 0);
      resp_ready  = ((cyc / 500) % 2 == 1) ? ($urandom_range(0, 7) == 0)
                                           : ($urandom_range(0, 2) != 0);
      drain_req   = ($urandom_range(0, 63) == 0);
      if (pend > 0 && $urandom_range(0, 2) == 0) begin
        nmc_qr_resp.valid  = 1'b1;
        nmc_qr_resp.found  = 1'($urandom_range(0, 1));
        nmc_qr_resp.result = 8'($urandom_range(0, 255));
        pend--;
      end else nmc_qr_resp = '0;
      @(negedge clk);
      pushed = nqr_push;
      step();
      if (pushed) pend++;
    end
    cmd_valid = 1'b0; nmc_qr_resp = '0; drain_req = 1'b0; resp_ready = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
